mem_access: RTL and testbench

Memory stage of the in-order integer pipeline. It sits between execute and writeback. It performs loads and stores over a single-outstanding request/acknowledge data bus, aligns and extends load data, and detects misaligned accesses. It presents writeback with one `issued_instr_t` plus one `reg_data_t` per cycle. It stalls upstream while an access is pending and drops all in-flight work when writeback signals a flush.

---
 rtl/mem_access.sv | 203 ++++++++++++++++++++
 tb/tb_mem_access.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// rtl/mem_access.sv - pipeline memory stage: single-outstanding data bus access, load alignment, misalign detection
package mem_pkg;
    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_t;

    typedef enum logic [3:0] {
        EXCEPT_NONE           = 4'd0,
        EXCEPT_LOAD_MISALIGN  = 4'd4,
        EXCEPT_STORE_MISALIGN = 4'd6
    } except_code_t;

    typedef struct packed {
        mem_op_t    mem_op;
        logic [1:0] mem_size;
        logic       mem_unsigned;
        logic [4:0] rd;
    } decode_t;

    typedef struct packed {
        logic         valid;
        except_code_t code;
    } except_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        decode_t     decode;
        except_t     except;
    } issued_instr_t;

    typedef logic [31:0] reg_data_t;
endpackage

module mem_access
    import mem_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_flush,
    input  issued_instr_t i_instr,
    input  logic [31:0]   i_data,
    input  logic [31:0]   i_store_data,
    output logic          o_stall,
    output issued_instr_t o_instr,
    output logic [31:0]   o_data,
    output logic          o_dbus_req,
    output logic          o_dbus_we,
    output logic [31:0]   o_dbus_addr,
    output logic [3:0]    o_dbus_be,
    output logic [31:0]   o_dbus_wdata,
    input  logic          i_dbus_ack,
    input  logic [31:0]   i_dbus_rdata
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    issued_instr_t out_instr_q, out_instr_d;
    reg_data_t     out_data_q, out_data_d;
    issued_instr_t hold_instr_q, hold_instr_d;
    logic [31:0]   hold_addr_q, hold_addr_d;
    logic          bus_we_q, bus_we_d;
    logic [31:0]   bus_addr_q, bus_addr_d;
    logic [3:0]    bus_be_q, bus_be_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    is_misaligned = 1'b0;
            2'd1:    is_misaligned = off[0];
            default: is_misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    byte_enables = 4'b0001 << off;
            2'd1:    byte_enables = 4'b0011 << off;
            default: byte_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] sd);
        case (size)
            2'd0:    lane_data = {4{sd[7:0]}};
            2'd1:    lane_data = {2{sd[15:0]}};
            default: lane_data = sd;
        endcase
    endfunction

    function automatic logic [31:0] load_align(input logic [31:0] rdata, input logic [1:0] off,
                                               input logic [1:0] size, input logic zext);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'd0:    load_align = zext ? {24'd0, b} : {{24{b[7]}}, b};
            2'd1:    load_align = zext ? {16'd0, h} : {{16{h[15]}}, h};
            default: load_align = rdata;
        endcase
    endfunction

    logic in_is_mem;
    assign in_is_mem = i_instr.valid && !i_instr.except.valid &&
                       (i_instr.decode.mem_op == MEM_LOAD || i_instr.decode.mem_op == MEM_STORE);

    always_comb begin
        state_d      = state_q;
        out_instr_d  = '0;
        out_data_d   = '0;
        hold_instr_d = hold_instr_q;
        hold_addr_d  = hold_addr_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;

        if (i_flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!in_is_mem) begin
                        out_instr_d = i_instr;
                        out_data_d  = i_data;
                    end else if (is_misaligned(i_instr.decode.mem_size, i_data[1:0])) begin
                        out_instr_d              = i_instr;
                        out_instr_d.except.valid = 1'b1;
                        out_instr_d.except.code  = (i_instr.decode.mem_op == MEM_LOAD) ?
                                                   EXCEPT_LOAD_MISALIGN : EXCEPT_STORE_MISALIGN;
                        out_data_d               = i_data;
                    end else begin
                        // Bus fields are captured here so they stay stable for the whole request.
                        hold_instr_d = i_instr;
                        hold_addr_d  = i_data;
                        bus_we_d     = (i_instr.decode.mem_op == MEM_STORE);
                        bus_addr_d   = {i_data[31:2], 2'b00};
                        bus_be_d     = byte_enables(i_instr.decode.mem_size, i_data[1:0]);
                        bus_wdata_d  = lane_data(i_instr.decode.mem_size, i_store_data);
                        state_d      = WAIT;
                    end
                end
                WAIT: begin
                    if (i_dbus_ack) begin
                        out_instr_d = hold_instr_q;
                        out_data_d  = bus_we_q ? hold_addr_q :
                                      load_align(i_dbus_rdata, hold_addr_q[1:0],
                                                 hold_instr_q.decode.mem_size,
                                                 hold_instr_q.decode.mem_unsigned);
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            out_instr_q  <= '0;
            out_data_q   <= '0;
            hold_instr_q <= '0;
            hold_addr_q  <= '0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= '0;
            bus_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            out_instr_q  <= out_instr_d;
            out_data_q   <= out_data_d;
            hold_instr_q <= hold_instr_d;
            hold_addr_q  <= hold_addr_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
        end
    end

    assign o_stall      = (state_q == WAIT);
    assign o_dbus_req   = (state_q == WAIT) && !i_flush;
    assign o_instr      = out_instr_q;
    assign o_data       = out_data_q;
    assign o_dbus_we    = bus_we_q;
    assign o_dbus_addr  = bus_addr_q;
    assign o_dbus_be    = bus_be_q;
    assign o_dbus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed bench for mem_access with a reference model and per-cycle compare
module tb_mem_access;
    import mem_pkg::*;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_flush;
    issued_instr_t i_instr;
    logic [31:0]   i_data;
    logic [31:0]   i_store_data;
    logic          o_stall;
    issued_instr_t o_instr;
    logic [31:0]   o_data;
    logic          o_dbus_req;
    logic          o_dbus_we;
    logic [31:0]   o_dbus_addr;
    logic [3:0]    o_dbus_be;
    logic [31:0]   o_dbus_wdata;
    logic          i_dbus_ack;
    logic [31:0]   i_dbus_rdata;

    mem_access dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_flush      (i_flush),
        .i_instr      (i_instr),
        .i_data       (i_data),
        .i_store_data (i_store_data),
        .o_stall      (o_stall),
        .o_instr      (o_instr),
        .o_data       (o_data),
        .o_dbus_req   (o_dbus_req),
        .o_dbus_we    (o_dbus_we),
        .o_dbus_addr  (o_dbus_addr),
        .o_dbus_be    (o_dbus_be),
        .o_dbus_wdata (o_dbus_wdata),
        .i_dbus_ack   (i_dbus_ack),
        .i_dbus_rdata (i_dbus_rdata)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic issued_instr_t mk(input logic v, input mem_op_t op, input logic [1:0] sz,
                                         input logic uns, input logic exc);
        issued_instr_t t;
        t                     = '0;
        t.valid               = v;
        t.pc                  = 32'h4000_0010;
        t.decode.mem_op       = op;
        t.decode.mem_size     = sz;
        t.decode.mem_unsigned = uns;
        t.decode.rd           = 5'd7;
        t.except.valid        = exc;
        t.except.code         = exc ? EXCEPT_LOAD_MISALIGN : EXCEPT_NONE;
        return t;
    endfunction

    // Reference rules: access width in bytes is 2**size, lanes start at the byte offset.
    function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [1:0] off);
        int nb;
        nb = (sz >= 2'd2) ? 4 : (1 << sz);
        return 4'(((1 << nb) - 1) << ((nb == 4) ? 0 : int'(off)));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] sd);
        if (sz == 2'd0) return 32'(sd[7:0]) * 32'h0101_0101;
        if (sz == 2'd1) return 32'(sd[15:0]) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] off,
                                             input logic [1:0] sz, input logic uns);
        logic [31:0] w;
        w = rd >> (int'(off) * 8);
        if (sz == 2'd0) return uns ? (w & 32'h0000_00FF) : 32'($signed(w[7:0]));
        if (sz == 2'd1) return uns ? (w & 32'h0000_FFFF) : 32'($signed(w[15:0]));
        return rd;
    endfunction

    logic          m_busy     = 1'b0;
    issued_instr_t m_instr    = '0;
    logic [31:0]   m_addr     = '0;
    logic [31:0]   m_sdata    = '0;
    logic          e_bubble   = 1'b0;
    issued_instr_t e_instr    = '0;
    logic [31:0]   e_data     = '0;
    logic          e_bus_zero = 1'b1;
    int            acc_count  = 0;

    always @(negedge i_clk) begin
        logic is_mem;
        logic [1:0] sz;
        chk("stall", 64'(o_stall), 64'(m_busy));
        chk("req", 64'(o_dbus_req), 64'(m_busy && !i_flush));
        if (m_busy) begin
            sz = m_instr.decode.mem_size;
            chk("bus_we", 64'(o_dbus_we), 64'(m_instr.decode.mem_op == MEM_STORE));
            chk("bus_addr", 64'(o_dbus_addr), 64'(m_addr & 32'hFFFF_FFFC));
            chk("bus_be", 64'(o_dbus_be), 64'(ref_be(sz, m_addr[1:0])));
            if (m_instr.decode.mem_op == MEM_STORE)
                chk("bus_wdata", 64'(o_dbus_wdata), 64'(ref_wdata(sz, m_sdata)));
        end else if (e_bus_zero) begin
            chk("rst_bus", {o_dbus_wdata, o_dbus_addr[27:0], o_dbus_be}, 64'd0);
            chk("rst_we", 64'(o_dbus_we), 64'd0);
        end
        chk("out_valid", 64'(o_instr.valid), 64'(e_bubble ? 1'b0 : e_instr.valid));
        if (!e_bubble) begin
            chk("out_instr", 64'(o_instr), 64'(e_instr));
            chk("out_data", 64'(o_data), 64'(e_data));
        end
        if (o_dbus_req && i_dbus_ack) acc_count++;

        e_bubble = 1'b1;
        if (!i_rst_n) begin
            m_busy     = 1'b0;
            e_bubble   = 1'b0;
            e_instr    = '0;
            e_data     = '0;
            e_bus_zero = 1'b1;
        end else if (i_flush) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (i_dbus_ack) begin
                e_bubble = 1'b0;
                e_instr  = m_instr;
                e_data   = (m_instr.decode.mem_op == MEM_STORE) ? m_addr :
                           ref_load(i_dbus_rdata, m_addr[1:0], m_instr.decode.mem_size,
                                    m_instr.decode.mem_unsigned);
                m_busy   = 1'b0;
            end
        end else begin
            sz     = i_instr.decode.mem_size;
            is_mem = i_instr.valid && !i_instr.except.valid &&
                     (i_instr.decode.mem_op == MEM_LOAD || i_instr.decode.mem_op == MEM_STORE);
            e_bubble = 1'b0;
            e_instr  = i_instr;
            e_data   = i_data;
            if (is_mem && (int'(i_data[1:0]) % ((sz >= 2'd2) ? 4 : (1 << sz))) != 0) begin
                e_instr.except.valid = 1'b1;
                e_instr.except.code  = (i_instr.decode.mem_op == MEM_LOAD) ?
                                       EXCEPT_LOAD_MISALIGN : EXCEPT_STORE_MISALIGN;
            end else if (is_mem) begin
                e_bubble   = 1'b1;
                m_busy     = 1'b1;
                m_instr    = i_instr;
                m_addr     = i_data;
                m_sdata    = i_store_data;
                e_bus_zero = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    task automatic present(input issued_instr_t t, input logic [31:0] d, input logic [31:0] sd);
        i_instr      = t;
        i_data       = d;
        i_store_data = sd;
    endtask

    task automatic go_idle();
        present(mk(1'b0, MEM_NONE, 2'd0, 1'b0, 1'b0), 32'd0, 32'd0);
    endtask

    // Runs one access acked on the n-th request cycle; returns just before the result is sampled.
    task automatic do_access(input issued_instr_t t, input logic [31:0] a, input logic [31:0] sd,
                             input int n, input logic [31:0] rdata,
                             output logic we_seen, output logic [3:0] be_seen,
                             output logic [31:0] wd_seen);
        step();
        present(t, a, sd);
        for (int k = 1; k <= n; k++) begin
            step();
            i_dbus_ack   = (k == n);
            i_dbus_rdata = rdata;
            @(negedge i_clk);
            if (k == 1) begin
                we_seen = o_dbus_we;
                be_seen = o_dbus_be;
                wd_seen = o_dbus_wdata;
            end
        end
        step();
        i_dbus_ack = 1'b0;
        go_idle();
        @(negedge i_clk);
    endtask

    logic        we_s;
    logic [3:0]  be_s;
    logic [31:0] wd_s;
    int          acc_before;

    initial begin
        i_rst_n      = 1'b0;
        i_flush      = 1'b0;
        i_dbus_ack   = 1'b0;
        i_dbus_rdata = '0;
        go_idle();
        repeat (3) step();
        @(negedge i_clk);
        chk("lit_rst_data", 64'(o_data), 64'd0);
        chk("lit_rst_req", 64'({o_dbus_req, o_stall}), 64'd0);
        step();
        i_rst_n = 1'b1;

        present(mk(1'b1, MEM_NONE, 2'd0, 1'b0, 1'b0), 32'h0000_1234, 32'd0);
        step();
        go_idle();
        @(negedge i_clk);
        chk("lit_alu_data", 64'(o_data), 64'h1234);
        chk("lit_alu_valid", 64'({o_instr.valid, o_dbus_req, o_stall}), 64'b100);

        step();
        present(mk(1'b1, MEM_LOAD, 2'd2, 1'b0, 1'b0), 32'h0000_0100, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step();
            i_dbus_ack   = (k == 3);
            i_dbus_rdata = 32'hDEAD_BEEF;
            @(negedge i_clk);
            chk("lit_lw_req", 64'({o_dbus_req, o_stall, o_dbus_we}), 64'b110);
            chk("lit_lw_addr", 64'({o_dbus_addr, o_dbus_be}), {28'd0, 32'h0000_0100, 4'hF});
        end
        step();
        i_dbus_ack = 1'b0;
        go_idle();
        @(negedge i_clk);
        chk("lit_lw_data", 64'(o_data), 64'hDEAD_BEEF);
        chk("lit_lw_valid", 64'(o_instr.valid), 64'd1);

        do_access(mk(1'b1, MEM_LOAD, 2'd0, 1'b0, 1'b0), 32'h103, 32'd0, 1, 32'h8000_0000, we_s, be_s, wd_s);
        chk("lit_lb_be", 64'(be_s), 64'b1000);
        chk("lit_lb_data", 64'(o_data), 64'hFFFF_FF80);
        do_access(mk(1'b1, MEM_LOAD, 2'd0, 1'b1, 1'b0), 32'h103, 32'd0, 1, 32'h8000_0000, we_s, be_s, wd_s);
        chk("lit_lbu_data", 64'(o_data), 64'h0000_0080);
        do_access(mk(1'b1, MEM_STORE, 2'd1, 1'b0, 1'b0), 32'h102, 32'h0000_ABCD, 2, 32'd0, we_s, be_s, wd_s);
        chk("lit_sh_bus", {27'd0, we_s, be_s, wd_s}, {27'd0, 1'b1, 4'b1100, 32'hABCD_ABCD});
        chk("lit_sh_data", 64'(o_data), 64'h102);
        do_access(mk(1'b1, MEM_LOAD, 2'd1, 1'b0, 1'b0), 32'h302, 32'd0, 1, 32'h8001_1234, we_s, be_s, wd_s);
        chk("lit_lh_data", 64'(o_data), 64'hFFFF_8001);
        do_access(mk(1'b1, MEM_LOAD, 2'd1, 1'b1, 1'b0), 32'h300, 32'd0, 2, 32'h8001_F234, we_s, be_s, wd_s);
        chk("lit_lhu_data", 64'(o_data), 64'h0000_F234);
        do_access(mk(1'b1, MEM_STORE, 2'd0, 1'b0, 1'b0), 32'h101, 32'h1234_565A, 1, 32'd0, we_s, be_s, wd_s);
        chk("lit_sb_bus", {28'd0, be_s, wd_s}, {28'd0, 4'b0010, 32'h5A5A_5A5A});

        step();
        present(mk(1'b1, MEM_LOAD, 2'd2, 1'b0, 1'b0), 32'h102, 32'd0);
        step();
        go_idle();
        @(negedge i_clk);
        chk("lit_mis_req", 64'(o_dbus_req), 64'd0);
        chk("lit_mis_exc", 64'({o_instr.valid, o_instr.except}), 64'b1_1_0100);
        chk("lit_mis_data", 64'(o_data), 64'h102);
        step();
        present(mk(1'b1, MEM_STORE, 2'd1, 1'b0, 1'b0), 32'h201, 32'h55);
        step();
        present(mk(1'b1, MEM_LOAD, 2'd2, 1'b0, 1'b1), 32'h200, 32'd0);
        @(negedge i_clk);
        chk("lit_smis_exc", 64'(o_instr.except), 64'b1_0110);
        step();
        go_idle();
        @(negedge i_clk);
        chk("lit_pre_exc", 64'({o_instr.valid, o_dbus_req, o_data}), {30'd0, 2'b10, 32'h200});

        step();
        present(mk(1'b1, MEM_STORE, 2'd2, 1'b0, 1'b0), 32'h400, 32'h1111_2222);
        step();
        step();
        acc_before = acc_count;
        i_flush    = 1'b1;
        i_dbus_ack = 1'b1;
        @(negedge i_clk);
        chk("lit_flush_req", 64'(o_dbus_req), 64'd0);
        step();
        i_flush    = 1'b0;
        i_dbus_ack = 1'b0;
        go_idle();
        @(negedge i_clk);
        chk("lit_flush_out", 64'({o_instr.valid, o_stall}), 64'd0);
        chk("lit_flush_acc", 64'(acc_count), 64'(acc_before));

        present(mk(1'b1, MEM_NONE, 2'd0, 1'b0, 1'b0), 32'h77, 32'd0);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        go_idle();
        @(negedge i_clk);
        chk("lit_flush_idle", 64'(o_instr.valid), 64'd0);

        step();
        present(mk(1'b1, MEM_LOAD, 2'd2, 1'b0, 1'b0), 32'h500, 32'd0);
        step();
        step();
        i_rst_n = 1'b0;
        step();
        @(negedge i_clk);
        chk("lit_rstw_out", 64'({o_instr.valid, o_data}), 64'd0);
        chk("lit_rstw_bus", {o_dbus_req, o_stall, o_dbus_we, o_dbus_be, o_dbus_addr[24:0]}, 64'd0);
        step();
        i_rst_n = 1'b1;
        go_idle();
        repeat (3) step();
        @(negedge i_clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
